// File: rtl/mac_dot_ctrl.sv
// mac_dot_ctrl -- sequencer for length-N dot-product jobs on the shared
// 8x8 MAC datapath (m = (x1*x2)>>6, y accumulates m, wraps at 2^YW).
//
// Optional feature macro: MAC_DOT_CTRL_OVF_EN
//   defined   : sticky accumulator-wrap flag on ovf (prev_y tracker)
//   undefined : ovf tied low, no prev_y register
//
// Ports:
//   clk, reset         clock (posedge) and synchronous active-high reset
//   start, len         job request (sampled in IDLE) and number of pairs
//   busy               high whenever a job is in progress (state != IDLE)
//   in_valid, in_ready operand-pair handshake
//   in_a, in_b         operand pair
//   mac_x1, mac_x2     registered operands to the MAC (0 when no handshake)
//   mac_clr            MAC reset: reset OR CLEAR state (combinational)
//   mac_y              MAC accumulator output
//   done, result       one-cycle completion pulse and held job result
//   count              pairs accepted in the current job
//   ovf                sticky wrap flag, valid alongside done
module mac_dot_ctrl #(
  parameter int DW         = 8,
  parameter int YW         = 10,
  parameter int LEN_W      = 5,
  parameter int CLR_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a,
  input  logic [DW-1:0]    in_b,
  output logic [DW-1:0]    mac_x1,
  output logic [DW-1:0]    mac_x2,
  output logic             mac_clr,
  input  logic [YW-1:0]    mac_y,
  output logic             done,
  output logic [YW-1:0]    result,
  output logic [LEN_W-1:0] count,
  output logic             ovf
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int              CW       = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CW-1:0]   CLR_LAST = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0]   CLR_ONE  = CW'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic [2:0]       state;
  logic [LEN_W-1:0] len_q;
  logic [CW-1:0]    clr_cnt;
  logic             drain_cnt;
  logic             hs;
  logic             last_hs;
  logic             accept;

  assign busy     = (state != S_IDLE);
  assign in_ready = (state == S_RUN) && (count < len_q);
  assign hs       = in_valid & in_ready;
  // count < len_q holds in RUN, so count + 1 cannot overflow here
  assign last_hs  = hs && ((count + LEN_ONE) == len_q);
  assign accept   = (state == S_IDLE) && start;
  assign mac_clr  = reset | (state == S_CLEAR);

  // job length is a data latch: no reset needed, only read after CLEAR
  always_ff @(posedge clk) begin
    if (accept) len_q <= len;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= '0;
      done      <= 1'b0;
      result    <= '0;
      mac_x1    <= '0;
      mac_x2    <= '0;
      clr_cnt   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      done <= 1'b0;
      // zero operands add nothing to y, so idle cycles are harmless bubbles
      mac_x1 <= hs ? in_a : '0;
      mac_x2 <= hs ? in_b : '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            count   <= '0;
            clr_cnt <= '0;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            drain_cnt <= 1'b0;
            state     <= (len_q == '0) ? S_DRAIN : S_RUN;
          end else begin
            clr_cnt <= clr_cnt + CLR_ONE;
          end
        end
        S_RUN: begin
          if (hs) begin
            count <= count + LEN_ONE;
            if (last_hs) begin
              drain_cnt <= 1'b0;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // two cycles: one for the MAC to take the last pair, one for y
          if (drain_cnt) begin
            result <= mac_y;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MAC_DOT_CTRL_OVF_EN
  logic [YW-1:0] prev_y;
  logic          track;

  assign track = (state == S_RUN) || (state == S_DRAIN);

  // y starts from 0 after CLEAR; each step adds m < 2^YW, so any drop is a wrap
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) prev_y <= '0;
    else if (track)       prev_y <= mac_y;
  end

  always_ff @(posedge clk) begin
    if (reset)                        ovf <= 1'b0;
    else if (accept)                  ovf <= 1'b0;
    else if (track && mac_y < prev_y) ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
